spi_mem_arb: RTL and testbench

- Arbitrates the shared memory SPI port (config flash on CS0, PSRAM on CS1, WP/HOLD tied high) between two SPI masters:
  - requester 0: CPU SPI0 master;
  - requester 1: a streaming/DMA reader (e.g. LCD framebuffer fetch from PSRAM).
- Grants are whole transactions, round-robin between the two requesters.
- Enforces a chip-select deselect guard time between owners and flags over-long transactions (PSRAM tCEM).
- Sits between `system` and the MEM_SPI pads.

---
 rtl/spi_arb_pkg.sv | 31 +++
 rtl/spi_arb_mux.sv | 47 ++++
 rtl/spi_mem_arb.sv | 145 ++++++++++++++
 tb/tb_spi_mem_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared encodings for the memory SPI arbiter: owner codes, FSM states and
// the round-robin pick used whenever the bus is free.
package spi_arb_pkg;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_R0   = 2'b01;
   localparam logic [1:0] OWN_R1   = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      GUARD = 2'd3
   } state_t;

   // last = 1 means r1 owned most recently, so r0 wins a tie.
   function automatic state_t arb_pick(input logic r0, input logic r1, input logic last);
      state_t pick;
      if (r0 && r1) begin
         pick = last ? OWN0 : OWN1;
      end else if (r0) begin
         pick = OWN0;
      end else if (r1) begin
         pick = OWN1;
      end else begin
         pick = IDLE;
      end
      return pick;
   endfunction

endpackage

// File: rtl/spi_arb_mux.sv
// Combinational steering of the shared SPI pads: the owner's drive reaches
// the bus, everyone else sees idle levels and miso held high.
module spi_arb_mux
   import spi_arb_pkg::*;
#(
   parameter int NCS  = 2,
   parameter bit CPOL = 1'b0
) (
   input  logic [1:0]     owner,
   input  logic           r0_sclk,
   input  logic           r0_mosi,
   input  logic [NCS-1:0] r0_cs_n,
   input  logic           r1_sclk,
   input  logic           r1_mosi,
   input  logic [NCS-1:0] r1_cs_n,
   input  logic           bus_miso,
   output logic           bus_sclk,
   output logic           bus_mosi,
   output logic [NCS-1:0] bus_cs_n,
   output logic           r0_miso,
   output logic           r1_miso
);

   always_comb begin
      bus_sclk = CPOL;
      bus_mosi = 1'b0;
      bus_cs_n = '1;
      r0_miso  = 1'b1;
      r1_miso  = 1'b1;
      case (owner)
         OWN_R0: begin
            bus_sclk = r0_sclk;
            bus_mosi = r0_mosi;
            bus_cs_n = r0_cs_n;
            r0_miso  = bus_miso;
         end
         OWN_R1: begin
            bus_sclk = r1_sclk;
            bus_mosi = r1_mosi;
            bus_cs_n = r1_cs_n;
            r1_miso  = bus_miso;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/spi_mem_arb.sv
// Round-robin, whole-transaction arbiter for the shared flash/PSRAM SPI port,
// with a deselect guard between owners and a sticky over-long-hold flag.
module spi_mem_arb
   import spi_arb_pkg::*;
#(
   parameter int NCS       = 2,
   parameter int GUARD_CYC = 4,
   parameter int MAX_HOLD  = 192,
   parameter bit CPOL      = 1'b0,
   parameter int HW        = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           r0_req,
   output logic           r0_gnt,
   input  logic           r0_sclk,
   input  logic           r0_mosi,
   input  logic [NCS-1:0] r0_cs_n,
   output logic           r0_miso,
   input  logic           r1_req,
   output logic           r1_gnt,
   input  logic           r1_sclk,
   input  logic           r1_mosi,
   input  logic [NCS-1:0] r1_cs_n,
   output logic           r1_miso,
   output logic           bus_sclk,
   output logic           bus_mosi,
   output logic [NCS-1:0] bus_cs_n,
   input  logic           bus_miso,
   output logic [1:0]     owner,
   output logic           ovr,
   input  logic           ovr_clr
);

   localparam logic [HW-1:0] GUARD_LAST = HW'(GUARD_CYC - 1);
   localparam logic [HW-1:0] HOLD_LIM   = HW'(MAX_HOLD);
   localparam bit            HOLD_EN    = (MAX_HOLD != 0);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [HW-1:0] guard_q, guard_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          ovr_q, ovr_d;
   logic          owned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         guard_q <= '0;
         hold_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         guard_q <= guard_d;
         hold_q  <= hold_d;
         ovr_q   <= ovr_d;
      end
   end

   assign owned = (state_q == OWN0) || (state_q == OWN1);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE:  state_d = arb_pick(r0_req, r1_req, last_q);
         OWN0: begin
            if (!r0_req) begin
               state_d = GUARD;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            if (!r1_req) begin
               state_d = GUARD;
               last_d  = 1'b1;
            end
         end
         // The last guard edge arbitrates directly so no idle cycle is added.
         GUARD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = arb_pick(r0_req, r1_req, last_q);
            end
         end
         default: state_d = IDLE;
      endcase

      guard_d = (state_q == GUARD) ? guard_q + 1'b1 : '0;

      // Held at zero outside ownership so each grant starts counting from 0.
      hold_d = '0;
      if (owned) begin
         hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
      end

      ovr_d = ovr_q;
      if (ovr_clr) begin
         ovr_d = 1'b0;
      end
      if (HOLD_EN && owned && (hold_q == HOLD_LIM)) begin
         ovr_d = 1'b1;
      end
   end

   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      owner  = OWN_NONE;
      case (state_q)
         OWN0: begin
            r0_gnt = 1'b1;
            owner  = OWN_R0;
         end
         OWN1: begin
            r1_gnt = 1'b1;
            owner  = OWN_R1;
         end
         default: ;
      endcase
   end

   assign ovr = ovr_q;

   spi_arb_mux #(
      .NCS  (NCS),
      .CPOL (CPOL)
   ) u_mux (
      .owner    (owner),
      .r0_sclk  (r0_sclk),
      .r0_mosi  (r0_mosi),
      .r0_cs_n  (r0_cs_n),
      .r1_sclk  (r1_sclk),
      .r1_mosi  (r1_mosi),
      .r1_cs_n  (r1_cs_n),
      .bus_miso (bus_miso),
      .bus_sclk (bus_sclk),
      .bus_mosi (bus_mosi),
      .bus_cs_n (bus_cs_n),
      .r0_miso  (r0_miso),
      .r1_miso  (r1_miso)
   );

endmodule

// File: tb/tb_spi_mem_arb.sv
// Scoreboarded bench for spi_mem_arb: a transaction-level ownership model
// predicts every cycle's pad/grant view, a negedge monitor compares.
module tb_spi_mem_arb;

   localparam int NCS       = 2;
   localparam int GUARD_CYC = 4;
   localparam int MAX_HOLD  = 192;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           r0_req = 1'b0, r1_req = 1'b0;
   logic           r0_gnt, r1_gnt;
   logic           r0_sclk = 1'b0, r0_mosi = 1'b0, r1_sclk = 1'b0, r1_mosi = 1'b0;
   logic [NCS-1:0] r0_cs_n = '1, r1_cs_n = '1;
   logic           r0_miso, r1_miso;
   logic           bus_sclk, bus_mosi;
   logic [NCS-1:0] bus_cs_n;
   logic           bus_miso = 1'b1;
   logic [1:0]     owner;
   logic           ovr;
   logic           ovr_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   // Requested input values for the next cycle, applied right after the edge.
   logic           n_reset = 1'b1, n_r0_req = 1'b0, n_r1_req = 1'b0, n_clr = 1'b0;
   logic [NCS-1:0] n_r0_cs = '1, n_r1_cs = '1;
   bit             clr_at_set = 1'b0;

   // Reference model: who owns the bus, guard cycles left, last owner, cycles owned.
   int m_owner = 0;
   int m_guard = 0;
   int m_last  = 1;
   int m_idx   = 0;
   bit m_ovr   = 1'b0;

   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   spi_mem_arb #(
      .NCS       (NCS),
      .GUARD_CYC (GUARD_CYC),
      .MAX_HOLD  (MAX_HOLD),
      .CPOL      (1'b0),
      .HW        (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .r0_req   (r0_req),
      .r0_gnt   (r0_gnt),
      .r0_sclk  (r0_sclk),
      .r0_mosi  (r0_mosi),
      .r0_cs_n  (r0_cs_n),
      .r0_miso  (r0_miso),
      .r1_req   (r1_req),
      .r1_gnt   (r1_gnt),
      .r1_sclk  (r1_sclk),
      .r1_mosi  (r1_mosi),
      .r1_cs_n  (r1_cs_n),
      .r1_miso  (r1_miso),
      .bus_sclk (bus_sclk),
      .bus_mosi (bus_mosi),
      .bus_cs_n (bus_cs_n),
      .bus_miso (bus_miso),
      .owner    (owner),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr)
   );

   function automatic logic [10:0] dut_obs();
      return {owner, r0_gnt, r1_gnt, bus_cs_n, bus_sclk, bus_mosi, r0_miso, r1_miso, ovr};
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_guard = 0;
      m_last  = 1;
      m_idx   = 0;
      m_ovr   = 1'b0;
   endtask

   task automatic arbitrate();
      if (r0_req && r1_req) m_owner = (m_last == 0) ? 2 : 1;
      else if (r0_req)      m_owner = 1;
      else if (r1_req)      m_owner = 2;
      else                  m_owner = 0;
      m_idx = 0;
   endtask

   task automatic model_edge();
      bit own_req;
      if (m_owner != 0 && m_idx == MAX_HOLD && MAX_HOLD != 0) m_ovr = 1'b1;
      else if (ovr_clr)                                         m_ovr = 1'b0;
      if (m_owner != 0) begin
         own_req = (m_owner == 1) ? r0_req : r1_req;
         if (own_req) begin
            m_idx++;
         end else begin
            m_last  = m_owner - 1;
            m_owner = 0;
            m_guard = GUARD_CYC;
         end
      end else if (m_guard > 0) begin
         m_guard--;
         if (m_guard == 0) arbitrate();
      end else begin
         arbitrate();
      end
   endtask

   task automatic push_exp();
      logic [1:0]     e_own;
      logic [NCS-1:0] e_cs;
      logic           e_sclk, e_mosi, e_m0, e_m1;
      e_own = 2'b00; e_cs = '1; e_sclk = 1'b0; e_mosi = 1'b0; e_m0 = 1'b1; e_m1 = 1'b1;
      if (m_owner == 1) begin
         e_own = 2'b01; e_cs = r0_cs_n; e_sclk = r0_sclk; e_mosi = r0_mosi; e_m0 = bus_miso;
      end else if (m_owner == 2) begin
         e_own = 2'b10; e_cs = r1_cs_n; e_sclk = r1_sclk; e_mosi = r1_mosi; e_m1 = bus_miso;
      end
      exp_q.push_back({e_own, m_owner == 1, m_owner == 2, e_cs, e_sclk, e_mosi, e_m0, e_m1, m_ovr});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else       model_edge();
   endtask

   task automatic apply_next();
      reset    = n_reset;
      r0_req   = n_r0_req;
      r1_req   = n_r1_req;
      r0_cs_n  = n_r0_cs;
      r1_cs_n  = n_r1_cs;
      ovr_clr  = n_clr || (clr_at_set && m_owner != 0 && m_idx == MAX_HOLD);
      r0_sclk  = 1'($urandom);
      r0_mosi  = 1'($urandom);
      r1_sclk  = 1'($urandom);
      r1_mosi  = 1'($urandom);
      bus_miso = 1'($urandom);
   endtask

   task automatic cycle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         apply_next();
         push_exp();
      end
   endtask

   task automatic check1(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every negedge with a pending expectation is one comparison.
   initial begin
      logic [10:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL obs t=%0t actual own=%b g=%b%b cs=%b sclk=%b mosi=%b miso=%b%b ovr=%b required own=%b g=%b%b cs=%b sclk=%b mosi=%b miso=%b%b ovr=%b",
                        $time, a[10:9], a[8], a[7], a[6:5], a[4], a[3], a[2], a[1], a[0],
                        e[10:9], e[8], e[7], e[6:5], e[4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      // Reset state observed with reset held, then released.
      cycle(2);
      n_reset = 1'b0;
      cycle(2);

      // Single grant: r0 alone.
      n_r0_req = 1'b1; n_r0_cs = 2'b10;
      cycle(6);
      n_r0_req = 1'b0; n_r0_cs = 2'b11;
      cycle(8);

      // Tie: r0 wins first; r1 drives cs=00 throughout and must stay masked.
      n_r0_req = 1'b1; n_r1_req = 1'b1; n_r0_cs = 2'b10; n_r1_cs = 2'b00;
      cycle(5);
      n_r0_req = 1'b0; n_r0_cs = 2'b11;
      cycle(10);
      // Back-to-back: r1 releases and re-requests immediately.
      n_r1_req = 1'b0;
      cycle(1);
      n_r1_req = 1'b1; n_r1_cs = 2'b01;
      cycle(8);
      // Next tie after r1's transaction goes to r0.
      n_r0_req = 1'b1; n_r0_cs = 2'b10;
      cycle(2);
      n_r1_req = 1'b0;
      cycle(1);
      n_r1_req = 1'b1;
      cycle(10);
      n_r0_req = 1'b0; n_r1_req = 1'b0; n_r0_cs = 2'b11; n_r1_cs = 2'b11;
      cycle(15);

      // Overrun: r0 holds long past MAX_HOLD, then clear pulse.
      n_r0_req = 1'b1; n_r0_cs = 2'b10;
      cycle(200);
      n_r0_req = 1'b0; n_r0_cs = 2'b11;
      cycle(6);
      n_clr = 1'b1;
      cycle(1);
      n_clr = 1'b0;
      cycle(3);
      // Set and clear on the same edge: set wins.
      clr_at_set = 1'b1;
      n_r0_req = 1'b1; n_r0_cs = 2'b10;
      cycle(200);
      clr_at_set = 1'b0;
      n_r0_req = 1'b0; n_r0_cs = 2'b11;
      cycle(8);
      n_clr = 1'b1;
      cycle(1);
      n_clr = 1'b0;

      // Async reset while r1 owns with cs=01.
      n_r1_req = 1'b1; n_r1_cs = 2'b01;
      cycle(10);
      check1("pre_reset_owner", {2'b00, owner}, 4'b0010);
      tick();
      apply_next();
      reset = 1'b1;
      #1;
      check1("async_cs", {2'b00, bus_cs_n}, 4'b0011);
      check1("async_gnt", {3'b000, r1_gnt}, 4'b0000);
      check1("async_owner", {2'b00, owner}, 4'b0000);
      model_reset();
      push_exp();
      n_reset = 1'b1;
      cycle(1);
      n_reset = 1'b0; n_r1_req = 1'b0; n_r1_cs = 2'b11;
      cycle(3);

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         if (!n_r0_req)          n_r0_req = ($urandom_range(5) == 0);
         else if (m_owner == 1)  n_r0_req = ($urandom_range(11) != 0);
         else                    n_r0_req = ($urandom_range(39) != 0);
         if (!n_r1_req)          n_r1_req = ($urandom_range(5) == 0);
         else if (m_owner == 2)  n_r1_req = ($urandom_range(11) != 0);
         else                    n_r1_req = ($urandom_range(39) != 0);
         n_r0_cs = 2'($urandom);
         n_r1_cs = 2'($urandom);
         n_clr   = ($urandom_range(29) == 0);
         cycle(1);
      end
      n_r0_req = 1'b0; n_r1_req = 1'b0; n_clr = 1'b0;
      cycle(10);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
